// File: rtl/duck_sprite_reader_if.sv
`default_nettype none
// ============================================================================
// Module : duck_sprite_reader_if
// Brief  : Beam/position inputs, frame RAM port and pixel outputs of the
//          duck sprite reader.
// Rev    : 1.0
// ============================================================================
interface duck_sprite_reader_if #(
    parameter int NUM_FRAMES = 2
);
    localparam int ANIM_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;

    logic              frame_start;
    logic [9:0]        DrawX;
    logic [9:0]        DrawY;
    logic [9:0]        duck_x;
    logic [9:0]        duck_y;
    logic              duck_en;
    logic              flip_h;
    logic [18:0]       read_address;
    logic [4:0]        ram_data;
    logic              pixel_on;
    logic [4:0]        color_idx;
    logic [ANIM_W-1:0] anim_frame;

    modport slave (
        input  frame_start, DrawX, DrawY, duck_x, duck_y, duck_en, flip_h,
        input  ram_data,
        output read_address, pixel_on, color_idx, anim_frame
    );

    modport master (
        output frame_start, DrawX, DrawY, duck_x, duck_y, duck_en, flip_h,
        output ram_data,
        input  read_address, pixel_on, color_idx, anim_frame
    );
endinterface
`default_nettype wire

// File: rtl/duck_sprite_reader.sv
`default_nettype none
// ============================================================================
// Module : duck_sprite_reader
// Brief  : Hit test, frame RAM address generation, 3-stage read alignment and
//          wing-flap animation counter for the 20x20 duck sprite.
// Rev    : 1.0
// ============================================================================
module duck_sprite_reader #(
    parameter int SPRITE_W    = 20,
    parameter int SPRITE_H    = 20,
    parameter int NUM_FRAMES  = 2,
    parameter int FRAME_HOLD  = 8,
    parameter int TRANSPARENT = 0
) (
    input  wire                         Clk,
    input  wire                         Reset,
    duck_sprite_reader_if.slave         bus
);
    localparam int ANIM_W      = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
    localparam int HOLD_W      = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
    localparam int FRAME_WORDS = SPRITE_W * SPRITE_H;

    logic [18:0]       addr_q, addr_d;
    logic              hit1_q, hit2_q;
    logic              pix_q;
    logic [4:0]        color_q;
    logic [ANIM_W-1:0] anim_q, anim_d;
    logic [HOLD_W-1:0] hold_q, hold_d;

    logic [10:0] w_x_end, w_y_end;
    logic [9:0]  w_lx, w_ly, w_col;
    logic        w_hit;

    // Box extents are formed at 11 bits so a duck near the right/bottom edge never wraps.
    always_comb begin
        w_x_end = {1'b0, bus.duck_x} + 11'(SPRITE_W);
        w_y_end = {1'b0, bus.duck_y} + 11'(SPRITE_H);
        w_hit   = bus.duck_en
                && ({1'b0, bus.DrawX} >= {1'b0, bus.duck_x})
                && ({1'b0, bus.DrawX} <  w_x_end)
                && ({1'b0, bus.DrawY} >= {1'b0, bus.duck_y})
                && ({1'b0, bus.DrawY} <  w_y_end);
        w_lx    = bus.DrawX - bus.duck_x;
        w_ly    = bus.DrawY - bus.duck_y;
        w_col   = bus.flip_h ? (10'(SPRITE_W - 1) - w_lx) : w_lx;
        addr_d  = 19'd0;
        if (w_hit) begin
            addr_d = 19'(anim_q) * 19'(FRAME_WORDS)
                   + 19'(w_ly) * 19'(SPRITE_W)
                   + 19'(w_col);
        end
    end

    always_comb begin
        hold_d = hold_q;
        anim_d = anim_q;
        if (bus.frame_start) begin
            if (hold_q == HOLD_W'(FRAME_HOLD - 1)) begin
                hold_d = '0;
                anim_d = (anim_q == ANIM_W'(NUM_FRAMES - 1)) ? '0 : anim_q + 1'b1;
            end else begin
                hold_d = hold_q + 1'b1;
            end
        end
    end

    // The RAM supplies the middle stage; hit2 tracks its registered read data.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            addr_q  <= '0;
            hit1_q  <= 1'b0;
            hit2_q  <= 1'b0;
            pix_q   <= 1'b0;
            color_q <= '0;
            anim_q  <= '0;
            hold_q  <= '0;
        end else begin
            addr_q  <= addr_d;
            hit1_q  <= w_hit;
            hit2_q  <= hit1_q;
            pix_q   <= hit2_q && (bus.ram_data != 5'(TRANSPARENT));
            color_q <= bus.ram_data;
            anim_q  <= anim_d;
            hold_q  <= hold_d;
        end
    end

    assign bus.read_address = addr_q;
    assign bus.pixel_on     = pix_q;
    assign bus.color_idx    = color_q;
    assign bus.anim_frame   = anim_q;
endmodule
`default_nettype wire

// File: tb/tb_duck_sprite_reader.sv
`default_nettype none
// ============================================================================
// Module : tb_duck_sprite_reader
// Brief  : Scoreboard bench for duck_sprite_reader with a registered RAM model.
// Rev    : 1.0
// ============================================================================
module tb_duck_sprite_reader;
    logic Clk   = 1'b0;
    logic Reset = 1'b1;
    always #5 Clk = ~Clk;

    duck_sprite_reader_if #(.NUM_FRAMES(2)) bus();

    duck_sprite_reader #(
        .SPRITE_W(20), .SPRITE_H(20), .NUM_FRAMES(2), .FRAME_HOLD(8), .TRANSPARENT(0)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    logic [4:0] mem [0:799];
    initial bus.ram_data = 5'd0;
    always @(posedge Clk)
        bus.ram_data <= (bus.read_address < 19'd800) ? mem[bus.read_address[9:0]] : 5'd0;

    typedef struct {
        longint      due;
        logic [18:0] addr;
        string       name;
    } addr_exp_t;

    typedef struct {
        longint     due;
        logic       pix;
        logic [4:0] col;
        logic       chkcol;
        string      name;
    } pix_exp_t;

    addr_exp_t aq[$];
    pix_exp_t  pq[$];
    int        checks   = 0;
    int        failures = 0;
    longint    cyc      = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge Clk) begin : monitor
        addr_exp_t a;
        pix_exp_t  p;
        while (aq.size() > 0 && aq[0].due <= cyc) begin
            a = aq.pop_front();
            chk({a.name, "_addr"}, longint'(bus.read_address), longint'(a.addr));
        end
        while (pq.size() > 0 && pq[0].due <= cyc) begin
            p = pq.pop_front();
            chk({p.name, "_pix"}, longint'(bus.pixel_on), longint'(p.pix));
            if (p.chkcol) chk({p.name, "_col"}, longint'(bus.color_idx), longint'(p.col));
        end
    end

    task automatic drive_now(input logic [9:0] dx, input logic [9:0] dy,
                             input logic [9:0] px, input logic [9:0] py,
                             input logic en, input logic fl, input logic fs);
        bus.DrawX = dx; bus.DrawY = dy; bus.duck_x = px; bus.duck_y = py;
        bus.duck_en = en; bus.flip_h = fl; bus.frame_start = fs;
    endtask

    task automatic push_exp(input string name, input logic [18:0] ea,
                            input logic ep, input logic [4:0] ec);
        aq.push_back('{due: cyc + 1, addr: ea, name: name});
        pq.push_back('{due: cyc + 3, pix: ep, col: ec, chkcol: 1'b1, name: name});
    endtask

    task automatic issue(input string name, input logic [9:0] dx, input logic [9:0] dy,
                         input logic [9:0] px, input logic [9:0] py,
                         input logic en, input logic fl, input logic fs,
                         input logic [18:0] ea, input logic ep, input logic [4:0] ec);
        @(negedge Clk);
        drive_now(dx, dy, px, py, en, fl, fs);
        push_exp(name, ea, ep, ec);
    endtask

    task automatic idle(input logic fs);
        @(negedge Clk);
        drive_now(10'd0, 10'd0, 10'd100, 10'd50, 1'b1, 1'b0, fs);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        for (int i = 0; i < 800; i++) mem[i] = 5'd7;
        mem[0] = 5'd5; mem[19] = 5'd0; mem[399] = 5'd12; mem[400] = 5'd9;
        drive_now(10'd0, 10'd0, 10'd100, 10'd50, 1'b1, 1'b0, 1'b0);

        repeat (3) @(negedge Clk);
        chk("rst_addr",  longint'(bus.read_address), 0);
        chk("rst_pix",   longint'(bus.pixel_on), 0);
        chk("rst_col",   longint'(bus.color_idx), 0);
        chk("rst_anim",  longint'(bus.anim_frame), 0);
        Reset = 1'b0;
        idle(1'b0); idle(1'b0);

        // Back-to-back stream: one coordinate per cycle.
        issue("tl",        10'd100, 10'd50,   10'd100, 10'd50,   1'b1, 1'b0, 1'b0, 19'd0,   1'b1, 5'd5);
        issue("br",        10'd119, 10'd69,   10'd100, 10'd50,   1'b1, 1'b0, 1'b0, 19'd399, 1'b1, 5'd12);
        issue("flip_tl",   10'd100, 10'd50,   10'd100, 10'd50,   1'b1, 1'b1, 1'b0, 19'd19,  1'b0, 5'd0);
        issue("flip_tr",   10'd119, 10'd50,   10'd100, 10'd50,   1'b1, 1'b1, 1'b0, 19'd0,   1'b1, 5'd5);
        issue("miss_x99",  10'd99,  10'd50,   10'd100, 10'd50,   1'b1, 1'b0, 1'b0, 19'd0,   1'b0, 5'd5);
        issue("miss_x120", 10'd120, 10'd50,   10'd100, 10'd50,   1'b1, 1'b0, 1'b0, 19'd0,   1'b0, 5'd5);
        issue("miss_y49",  10'd100, 10'd49,   10'd100, 10'd50,   1'b1, 1'b0, 1'b0, 19'd0,   1'b0, 5'd5);
        issue("miss_y70",  10'd100, 10'd70,   10'd100, 10'd50,   1'b1, 1'b0, 1'b0, 19'd0,   1'b0, 5'd5);
        issue("duck_off",  10'd100, 10'd50,   10'd100, 10'd50,   1'b0, 1'b0, 1'b0, 19'd0,   1'b0, 5'd5);
        issue("mid",       10'd110, 10'd60,   10'd100, 10'd50,   1'b1, 1'b0, 1'b0, 19'd210, 1'b1, 5'd7);
        issue("edge_miss", 10'd5,   10'd1012, 10'd1010, 10'd1010, 1'b1, 1'b0, 1'b0, 19'd0,  1'b0, 5'd5);
        issue("edge_hit",  10'd1015, 10'd1012, 10'd1010, 10'd1010, 1'b1, 1'b0, 1'b0, 19'd45, 1'b1, 5'd7);
        issue("edge_corner", 10'd1023, 10'd1023, 10'd1010, 10'd1010, 1'b1, 1'b0, 1'b0, 19'd273, 1'b1, 5'd7);
        repeat (4) idle(1'b0);

        for (int i = 1; i <= 7; i++) begin idle(1'b1); idle(1'b0); end
        chk("anim_after7", longint'(bus.anim_frame), 0);
        idle(1'b1); idle(1'b0);
        chk("anim_after8", longint'(bus.anim_frame), 1);
        issue("frame1_tl", 10'd100, 10'd50, 10'd100, 10'd50, 1'b1, 1'b0, 1'b0, 19'd400, 1'b1, 5'd9);
        for (int i = 9; i <= 15; i++) begin idle(1'b1); idle(1'b0); end
        chk("anim_after15", longint'(bus.anim_frame), 1);
        issue("fs_same_cycle", 10'd100, 10'd50, 10'd100, 10'd50, 1'b1, 1'b0, 1'b1, 19'd400, 1'b1, 5'd9);
        issue("fs_next_cycle", 10'd100, 10'd50, 10'd100, 10'd50, 1'b1, 1'b0, 1'b0, 19'd0,   1'b1, 5'd5);
        chk("anim_after16", longint'(bus.anim_frame), 0);
        repeat (4) idle(1'b0);

        // Asynchronous reset in the middle of a run of hits.
        for (int i = 0; i < 4; i++)
            issue("pre_rst", 10'd100, 10'd50, 10'd100, 10'd50, 1'b1, 1'b0, 1'b0, 19'd0, 1'b1, 5'd5);
        chk("pre_rst_pix_on", longint'(bus.pixel_on), 1);
        #2 Reset = 1'b1;
        #1;
        chk("async_rst_addr", longint'(bus.read_address), 0);
        chk("async_rst_pix",  longint'(bus.pixel_on), 0);
        chk("async_rst_col",  longint'(bus.color_idx), 0);
        aq.delete();
        pq.delete();
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        pq.push_back('{due: cyc + 1, pix: 1'b0, col: 5'd0, chkcol: 1'b0, name: "post_rst_e1"});
        pq.push_back('{due: cyc + 2, pix: 1'b0, col: 5'd0, chkcol: 1'b0, name: "post_rst_e2"});
        drive_now(10'd100, 10'd50, 10'd100, 10'd50, 1'b1, 1'b0, 1'b0);
        push_exp("post_rst_hit", 19'd0, 1'b1, 5'd5);
        repeat (6) idle(1'b0);

        chk("sb_drained", longint'(aq.size() + pq.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/duck_sprite_reader.md
# duck_sprite_reader

Read-side fetch engine for the 20x20 duck sprite frame RAMs. Each cycle it takes the VGA beam coordinate and the duck's screen position, decides whether the beam is inside the sprite box, and issues the RAM read address. It absorbs the RAM's one-cycle registered read latency and delivers a pipeline-aligned palette index plus opaque flag to the color mapper. It also owns the wing-flap animation frame counter, which selects among sprite frames packed back-to-back in one RAM.

## Interface
Parameters:
- SPRITE_W, 20, sprite width in pixels
- SPRITE_H, 20, sprite height in pixels
- NUM_FRAMES, 2, animation frames stored consecutively; stride is SPRITE_W*SPRITE_H words
- FRAME_HOLD, 8, number of frame_start pulses each animation frame is shown
- TRANSPARENT, 0, palette index treated as see-through

Ports:
- Clk  in  1  system clock; all state updates on rising edge
- Reset  in  1  asynchronous, active-high; clears all state immediately
- frame_start  in  1  one-cycle pulse, once per video frame at start of vertical blank
- DrawX  in  10  current beam column
- DrawY  in  10  current beam row
- duck_x  in  10  sprite top-left column
- duck_y  in  10  sprite top-left row
- duck_en  in  1  duck visible; when low, no hit is ever generated
- flip_h  in  1  mirror sprite horizontally (duck flying left)
- read_address  out  19  frame RAM read address (registered)
- ram_data  in  5  frame RAM data_Out; valid one cycle after read_address is sampled
- pixel_on  out  1  registered; current output pixel is opaque duck
- color_idx  out  5  registered palette index aligned with pixel_on
- anim_frame  out  $clog2(NUM_FRAMES)  current animation frame

## Operation
- Hit test, evaluated each cycle on the current inputs: DrawX >= duck_x, DrawX < duck_x+SPRITE_W, DrawY >= duck_y, DrawY < duck_y+SPRITE_H, and duck_en. Sums are computed at 11 bits, so a sprite near column/row 1023 never wraps.
- Local coordinates: lx = DrawX-duck_x, ly = DrawY-duck_y.
- Column: col = flip_h ? SPRITE_W-1-lx : lx.
- Address: anim_frame*SPRITE_W*SPRITE_H + ly*SPRITE_W + col, computed at 19 bits with zero-extension.
- On a miss, read_address is driven to 0.
- Pipeline:
  - S1: register read_address and hit1.
  - S2: the RAM registers its data; register hit2.
  - S3: color_idx <= ram_data; pixel_on <= hit2 && (ram_data != TRANSPARENT).
- On a miss, color_idx still loads ram_data, but pixel_on is 0. Downstream logic ignores color_idx when pixel_on is 0.
- Animation counter:
  - hold_cnt (0..FRAME_HOLD-1) increments on each frame_start.
  - On a frame_start with hold_cnt == FRAME_HOLD-1: hold_cnt wraps to 0 and anim_frame advances.
  - anim_frame after NUM_FRAMES-1 wraps to 0.
  - Counting continues regardless of duck_en.
- anim_frame changes only on a frame_start edge, so the sprite frame never changes mid-scan.
- duck_x, duck_y and flip_h are sampled every cycle with no internal latching. Game logic updates them only at frame_start.

## Timing
- Reset values: read_address=0, pixel_on=0, color_idx=0, anim_frame=0, hold_cnt=0, hit1=hit2=0.
- Latency:
  - DrawX/DrawY at edge N determine read_address after edge N+1.
  - The RAM holds data after edge N+2.
  - pixel_on/color_idx are valid after edge N+3.
- Fixed 3-cycle latency; the VGA pipeline delays its sync/blank signals by 3 to match.
- Throughput is one pixel per cycle with no stalls or backpressure.
- A frame_start on the same cycle as a hit: the address for that cycle uses the old anim_frame; the new frame applies from the next cycle.
- Reset mid-operation: all in-flight hits are discarded. pixel_on is 0 from reset assertion until 3 edges after deassertion at minimum.
- anim_frame update: on the edge sampling frame_start; visible on read_address one edge later.

## Test plan
- duck_x=100, duck_y=50, anim_frame=0, flip_h=0; DrawX=100, DrawY=50 -> read_address=0 after 1 edge. DrawX=119, DrawY=69 -> 399.
- Same position, flip_h=1, DrawX=100, DrawY=50 -> read_address=19. DrawX=119 -> 0.
- Boundary misses: DrawX=99, 120 or DrawY=49, 70 -> read_address=0 and pixel_on=0 three cycles later. duck_en=0 inside the box -> pixel_on=0.
- RAM model returning 5 at the hit pixel -> pixel_on=1, color_idx=5 exactly 3 edges after the coordinate. Returning TRANSPARENT (0) -> pixel_on=0.
- Animation with FRAME_HOLD=8:
  - 7 frame_start pulses -> anim_frame=0.
  - 8th pulse -> anim_frame=1; DrawX=100, DrawY=50 -> read_address=400.
  - 16th pulse -> anim_frame=0.
- Assert Reset asynchronously mid-scan while pixel_on=1 -> all outputs 0 immediately. After release, the first pixel_on=1 appears no earlier than 3 edges after a hit coordinate.
